// File: rtl/dmux8way16_router.sv
`default_nettype none
// ============================================================================
// Module   : dmux8way16_router
// Purpose  : Registered 1-to-8 word distributor with per-channel valid/ready
//            holding registers and a delivered-word counter.
//            Optional broadcast mode enabled by defining DMUX_BCAST_EN.
// Revision : 1.0  initial release
// ============================================================================
module dmux8way16_router #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   out,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [CNT_WIDTH-1:0] count
`ifdef DMUX_BCAST_EN
    ,
    input  logic                 bcast
`endif
);

    localparam int c_NCH = 8;

    logic [7:0]           r_valid;
    logic [WIDTH-1:0]     r_data [c_NCH];
    logic [CNT_WIDTH-1:0] r_count;

    logic [7:0]           w_pop;
    logic [7:0]           w_free;
    logic [7:0]           w_load;
    logic                 w_accept;
    logic                 w_bcast;
    logic [3:0]           w_pop_cnt;

`ifdef DMUX_BCAST_EN
    assign w_bcast = bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // A channel can take a word if it is empty or is being drained this edge.
    assign w_pop    = r_valid & out_ready;
    assign w_free   = ~r_valid | out_ready;
    assign in_ready = w_bcast ? (&w_free) : w_free[sel];
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_load = 8'h00;
        if (w_accept) begin
            w_load = w_bcast ? 8'hFF : (8'h01 << sel);
        end
    end

    always_comb begin
        w_pop_cnt = 4'd0;
        for (int i = 0; i < c_NCH; i++) begin
            w_pop_cnt = w_pop_cnt + 4'(w_pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 8'h00;
            r_count <= '0;
            for (int i = 0; i < c_NCH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            // A load on the same edge as a pop keeps the channel full.
            r_valid <= (r_valid & ~w_pop) | w_load;
            r_count <= r_count + CNT_WIDTH'(w_pop_cnt);
            for (int i = 0; i < c_NCH; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= in;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < c_NCH; k++) begin : g_out
            assign out[k*WIDTH +: WIDTH] = r_data[k];
        end
    endgenerate

    assign out_valid = r_valid;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dmux8way16_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux8way16_router
// Purpose  : Randomized and directed bench for dmux8way16_router against a
//            behavioural channel model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmux8way16_router;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   din;
    logic [2:0]     sel;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] dout;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [15:0]    count;
    logic           bcast;

    always #5 clk = ~clk;

    dmux8way16_router #(.WIDTH(W), .CNT_WIDTH(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef DMUX_BCAST_EN
        ,
        .bcast     (bcast)
`endif
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         m_valid [8];
    logic [W-1:0] m_data [8];
    int         m_count;
    logic [W-1:0] words [8] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                                16'h5678, 16'h6789, 16'h789A, 16'h89AB};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        bit all_free = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (m_valid[k] && !out_ready[k]) all_free = 1'b0;
        end
`ifdef DMUX_BCAST_EN
        if (bcast) return all_free;
`endif
        return !m_valid[sel] || out_ready[sel];
    endfunction

    function automatic logic [7:0] model_valid_vec();
        logic [7:0] v = 8'h00;
        for (int k = 0; k < 8; k++) v[k] = m_valid[k];
        return v;
    endfunction

    // Compare DUT against model mid-cycle, then advance the model across the edge.
    task automatic tick();
        bit acc;
        @(negedge clk);
        chk("out_valid", {24'h0, out_valid}, {24'h0, model_valid_vec()});
        chk("count", {16'h0, count}, m_count);
        chk("in_ready", {31'h0, in_ready}, {31'h0, model_ready()});
        for (int k = 0; k < 8; k++) begin
            if (m_valid[k]) chk($sformatf("out[%0d]", k), {16'h0, dout[k*W +: W]}, {16'h0, m_data[k]});
        end
        acc = in_valid && model_ready();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                m_valid[k] = 1'b0;
                m_data[k]  = '0;
            end
            m_count = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_valid[k] && out_ready[k]) begin
                    m_valid[k] = 1'b0;
                    m_count    = (m_count + 1) % 65536;
                end
            end
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    if (k == int'(sel) || bcast) begin
                        m_data[k]  = din;
                        m_valid[k] = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        int c0;
        bcast     = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        din       = 16'h1234;
        sel       = 3'd0;
        out_ready = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
        m_count  = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", {24'h0, out_valid}, 32'h0);
        chk("rst_count", {16'h0, count}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        tick();

        // Routing sweep
        for (int s = 0; s < 8; s++) begin
            sel      = 3'(s);
            din      = words[s];
            in_valid = 1'b1;
            tick();
            chk($sformatf("sweep_out[%0d]", s), {16'h0, dout[s*W +: W]}, {16'h0, words[s]});
        end
        in_valid = 1'b0;
        chk("sweep_valid", {24'h0, out_valid}, 32'hFF);
        tick();

        // Backpressure on channel 3
        sel = 3'd3; din = 16'hBEEF; in_valid = 1'b1; out_ready = 8'h00;
        tick();
        chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        chk("bp_hold", {16'h0, dout[3*W +: W]}, 32'h4567);
        out_ready = 8'h08;
        c0 = m_count;
        tick();
        in_valid = 1'b0; out_ready = 8'h00;
        chk("bp_new", {16'h0, dout[3*W +: W]}, 32'hBEEF);
        chk("bp_valid3", {31'h0, out_valid[3]}, 32'h1);
        chk("bp_count", {16'h0, count}, c0 + 1);
        tick();

        // Concurrent pops of all eight channels
        out_ready = 8'hFF;
        c0 = m_count;
        tick();
        out_ready = 8'h00;
        chk("pop8_valid", {24'h0, out_valid}, 32'h0);
        chk("pop8_count", {16'h0, count}, c0 + 8);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            sel       = 3'($urandom);
            din       = 16'($urandom);
            out_ready = 8'($urandom);
            tick();
        end

        // Counter wrap
        in_valid = 1'b0; out_ready = 8'h00; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b1; sel = 3'd0; din = 16'($urandom);
        tick();
        out_ready = 8'h01;
        for (int i = 0; i < 65535; i++) begin
            din = 16'($urandom);
            tick();
        end
        chk("wrap_ffff", {16'h0, count}, 32'hFFFF);
        tick();
        chk("wrap_zero", {16'h0, count}, 32'h0);

        // Reset while full and offering
        out_ready = 8'h00;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s); din = 16'($urandom);
            tick();
        end
        reset = 1'b1; sel = 3'd2; din = 16'h1111; in_valid = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", {24'h0, out_valid}, 32'h0);
        chk("midrst_count", {16'h0, count}, 32'h0);
        tick();

`ifdef DMUX_BCAST_EN
        sel = 3'd5; din = 16'h5555; in_valid = 1'b1; out_ready = 8'h00;
        tick();
        bcast = 1'b1; din = 16'hA5A5; sel = 3'd0;
        tick();
        chk("bc_in_ready", {31'h0, in_ready}, 32'h0);
        out_ready = 8'h20;
        tick();
        bcast = 1'b0; in_valid = 1'b0; out_ready = 8'h00;
        chk("bc_valid", {24'h0, out_valid}, 32'hFF);
        for (int k = 0; k < 8; k++) chk($sformatf("bc_out[%0d]", k), {16'h0, dout[k*W +: W]}, 32'hA5A5);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmux8way16_router.md
Name: dmux8way16_router

Overview:
- Registered 1-to-8 distributor for 16-bit words; the inverse of the Hack 8-way 16-bit multiplexer.
- One input stream with a 3-bit destination select. Each of eight output channels has a one-entry holding register with a valid/ready handshake.
- Sits between a single producer and eight consumers, e.g. a CPU-side write port fanning out to eight peripheral or RAM-bank queues.

Parameters:
- WIDTH, 16, data word width in bits
- CNT_WIDTH, 16, width of the delivered-word counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  input data word
- sel  input  3  destination channel; 0=a … 7=h
- in_valid  input  1  producer offers in/sel this cycle
- in_ready  output  1  router accepts in/sel this cycle
- out  output  8*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  8  channel k holds a word
- out_ready  input  8  consumer k takes its word this cycle
- count  output  CNT_WIDTH  total words delivered (popped) since reset
- bcast  input  1  broadcast request; exists only with DMUX_BCAST_EN

Behaviour:
- Clocking and reset: one clock `clk`. Reset is synchronous and active-high on port `reset`.
- Reset (sampled at a rising edge):
  - out_valid=0, out=0, count=0.
  - Any held words are discarded.
  - Reset overrides a simultaneous accept or pop.
- Per-channel state: one valid bit plus one WIDTH-bit data register. No other state machine; each channel toggles between EMPTY and FULL.
- Pop: out_valid[k] && out_ready[k] at an edge.
  - Channel k empties, unless refilled in the same edge.
  - count increments by 1 per popped word.
  - count adds popcount(pops) when several channels pop together, up to +8 per cycle.
  - count wraps modulo 2^CNT_WIDTH (16'hFFFF -> 16'h0000).
- in_ready is combinational: `in_ready = !out_valid[sel] || out_ready[sel]`.
  - in_ready depends only on the selected channel.
  - Other full channels never block.
- Accept: in_valid && in_ready at an edge.
  - out[sel] <= in and out_valid[sel] <= 1.
  - Latency 1 cycle: the word is visible on out/out_valid in the cycle after acceptance.
- Simultaneous pop and accept on the same channel: the new word replaces the old one and out_valid stays 1. Full throughput is one word per cycle per channel.
- Full channel with out_ready low: in_ready=0 for that sel. The producer must hold in/sel/in_valid stable until accepted.
- in_valid=0: no state change apart from pops; sel and in are don't-care.
- Data retention: data of an emptied channel holds its last value (not cleared). Bench must check data only when out_valid=1.
- Stall stability: out[k] never changes while out_valid[k]=1 and out_ready[k]=0.

Optional Feature:
- Macro: DMUX_BCAST_EN.
- Defined:
  - Port bcast exists.
  - With bcast=1, `in_ready = &(~out_valid | out_ready)`, i.e. all eight channels can take a word.
  - On accept, all eight channels load `in` and set out_valid, ignoring sel.
  - With bcast=0, behaviour is unicast as above.
- Undefined:
  - No bcast port and no broadcast logic.
  - Behaviour is unicast only.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, in=16'h1234 -> out_valid=8'h00, count=0, in_ready=1 after release.
- Routing sweep, one word per sel 0..7 (no pops) ->
  - Words: 16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB.
  - Each appears one cycle after accept on out[sel].
  - out_valid reaches 8'hFF; other channels unchanged.
- Backpressure: channel 3 full, out_ready=0, offer 16'hBEEF sel=3 ->
  - in_ready=0 and out[3] stays 16'h4567.
  - Raise out_ready[3] -> same-edge pop and accept; out[3]=16'hBEEF next cycle, out_valid[3]=1, count+1.
- Concurrent pops: all 8 full, out_ready=8'hFF for one cycle, in_valid=0 -> out_valid=8'h00, count increases by 8.
- Wrap and reset mid-operation:
  - Force 65535 pops -> count=16'hFFFF; one more pop -> 16'h0000.
  - Assert reset while channels full and in_valid=1 -> all cleared next cycle, nothing accepted.
- DMUX_BCAST_EN:
  - bcast=1, in=16'hA5A5 with channel 5 full and stalled -> in_ready=0.
  - Release channel 5 -> all 8 channels hold 16'hA5A5 next cycle.
